// File: rtl/cory_demux_pkg.sv
// rtl/cory_demux_pkg.sv - shared types and select-width helper for cory_demux
package cory_demux_pkg;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

  // Select width for R outputs; R above 32 is illegal and yields 0.
  function automatic int sel_width(input int r);
    if (r <= 2)       return 1;
    else if (r <= 4)  return 2;
    else if (r <= 8)  return 3;
    else if (r <= 16) return 4;
    else if (r <= 32) return 5;
    else              return 0;
  endfunction

endpackage

// File: rtl/cory_demux_slot.sv
// rtl/cory_demux_slot.sv - 2-entry per-output FIFO with registered occupancy
module cory_demux_slot
  import cory_demux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [N-1:0] push_d,
  input  logic         rdy,
  output logic         valid,
  output logic [N-1:0] head,
  output logic         has_room
);

  cnt_e         count, count_next;
  logic [N-1:0] second;
  logic         pop;

  assign valid    = (count != CNT_EMPTY);
  assign has_room = (count != CNT_FULL);
  assign pop      = valid & rdy;

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = (count == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
      2'b01:   count_next = (count == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) count <= CNT_EMPTY;
    else       count <= count_next;
  end

  // Head is entry 0; a pop shifts the second entry forward.
  always_ff @(posedge clk) begin
    unique case (count)
      CNT_EMPTY: if (push) head <= push_d;
      CNT_ONE: begin
        if (push && pop) head   <= push_d;
        else if (push)   second <= push_d;
      end
      CNT_FULL: begin
        if (pop) head <= second;
        if (push && pop) second <= push_d;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cory_demux.sv
// rtl/cory_demux.sv - registered 1-to-R demux joining a data and a select stream
module cory_demux
  import cory_demux_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 2,
  parameter int S = sel_width(R)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_a_v,
  input  logic [N-1:0]   i_a_d,
  output logic           o_a_r,
  input  logic           i_s_v,
  input  logic [S-1:0]   i_s_d,
  output logic           o_s_r,
  output logic [R-1:0]   o_zx_v,
  output logic [R*N-1:0] o_zx_d,
  input  logic [R-1:0]   i_zx_r,
  output logic           o_err
);

  localparam int RP = 1 << S;

  logic [R-1:0]  room_vec;
  logic [RP-1:0] room_pad;
  logic [R-1:0]  push;
  logic          sel_ok;
  logic          room;
  logic          open;
  logic          take;

`ifdef SIM
  initial begin
    if (R < 2 || R > 32) begin
      $display("cory_demux: R=%0d outside 2..32", R);
      $finish;
    end
  end
`endif

  // Pad the room vector to the full select range so any i_s_d indexes safely.
  always_comb begin
    room_pad          = '0;
    room_pad[R-1:0]   = room_vec;
  end

  assign sel_ok = (32'(i_s_d) < R);
  assign room   = room_pad[i_s_d];
  assign open   = (room | ~sel_ok) & ~reset;
  assign o_a_r  = i_s_v & open;
  assign o_s_r  = i_a_v & open;
  assign take   = i_a_v & i_s_v & open;

  always_ff @(posedge clk) begin
    if (reset) o_err <= 1'b0;
    else       o_err <= take & ~sel_ok;
  end

  for (genvar k = 0; k < R; k++) begin : g_slot
    assign push[k] = take & sel_ok & (i_s_d == S'(k));

    cory_demux_slot #(.N(N)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .push     (push[k]),
      .push_d   (i_a_d),
      .rdy      (i_zx_r[k]),
      .valid    (o_zx_v[k]),
      .head     (o_zx_d[k*N +: N]),
      .has_room (room_vec[k])
    );
  end

endmodule

// File: tb/tb_cory_demux.sv
// tb/tb_cory_demux.sv - scoreboard bench for cory_demux with R=3, N=8
module tb_cory_demux;

  localparam int N = 8;
  localparam int R = 3;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_a_v;
  logic [N-1:0]   i_a_d;
  logic           o_a_r;
  logic           i_s_v;
  logic [S-1:0]   i_s_d;
  logic           o_s_r;
  logic [R-1:0]   o_zx_v;
  logic [R*N-1:0] o_zx_d;
  logic [R-1:0]   i_zx_r;
  logic           o_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t0;
  bit mon_en = 1'b0;

  logic [N-1:0] q [R][$];
  logic         err_exp = 1'b0;
  logic         m_selok, m_room, m_ar, m_sr, m_acc;

  cory_demux #(.N(N), .R(R)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_a_v  (i_a_v),
    .i_a_d  (i_a_d),
    .o_a_r  (o_a_r),
    .i_s_v  (i_s_v),
    .i_s_d  (i_s_d),
    .o_s_r  (o_s_r),
    .o_zx_v (o_zx_v),
    .o_zx_d (o_zx_d),
    .i_zx_r (i_zx_r),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue depth is slot occupancy; updated for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < R; k++) begin
        check($sformatf("zx_v[%0d]", k), 32'(o_zx_v[k]), 32'(q[k].size() != 0));
        if (q[k].size() != 0)
          check($sformatf("zx_d[%0d]", k), 32'(o_zx_d[k*N +: N]), 32'(q[k][0]));
      end
      check("err", 32'(o_err), 32'(err_exp));
      m_selok = (i_s_d < 2'(R));
      m_room  = 1'b0;
      if (m_selok) m_room = (q[i_s_d].size() < 2);
      m_ar  = i_s_v & (m_room | ~m_selok) & ~reset;
      m_sr  = i_a_v & (m_room | ~m_selok) & ~reset;
      m_acc = i_a_v & i_s_v & m_ar;
      check("a_r", 32'(o_a_r), 32'(m_ar));
      check("s_r", 32'(o_s_r), 32'(m_sr));
      if (reset) begin
        for (int k = 0; k < R; k++) q[k].delete();
        err_exp = 1'b0;
      end else begin
        for (int k = 0; k < R; k++)
          if (q[k].size() != 0 && i_zx_r[k]) void'(q[k].pop_front());
        if (m_acc && m_selok) q[i_s_d].push_back(i_a_d);
        err_exp = m_acc & ~m_selok;
      end
    end
  end

  task automatic send(input logic [S-1:0] sel, input logic [N-1:0] data);
    i_a_v = 1'b1; i_s_v = 1'b1; i_s_d = sel; i_a_d = data;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (o_a_r) break;
      if (n == 50) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    i_a_v = 1'b0; i_s_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_a_v = 1'b0; i_s_v = 1'b0; i_a_d = '0; i_s_d = '0;
    i_zx_r = '1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check("rst_zx_v", 32'(o_zx_v), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Routing, back-to-back, all consumers ready
    send(2'd0, 8'h11);
    send(2'd2, 8'h33);
    send(2'd1, 8'h22);
    idle(3);

    // Back-pressure on output 1
    i_zx_r[1] = 1'b0;
    send(2'd1, 8'hA1);
    send(2'd1, 8'hA2);
    i_a_v = 1'b1; i_s_v = 1'b1; i_s_d = 2'd1; i_a_d = 8'hA3;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", 32'(o_a_r), 32'd0);
      check("bp_head", 32'(o_zx_d[N +: N]), 32'hA1);
    end
    @(posedge clk); #1 i_zx_r[1] = 1'b1;
    @(negedge clk);
    check("bp_bubble", 32'(o_a_r), 32'd0);
    @(negedge clk);
    check("bp_resume", 32'(o_a_r), 32'd1);
    @(posedge clk); #1 i_a_v = 1'b0; i_s_v = 1'b0;
    idle(4);

    // Output 2 full and stalled must not block output 0
    i_zx_r[2] = 1'b0;
    send(2'd2, 8'hC1);
    send(2'd2, 8'hC2);
    t0 = cyc;
    send(2'd0, 8'h01);
    send(2'd0, 8'h02);
    send(2'd0, 8'h03);
    send(2'd0, 8'h04);
    check("nb_rate", 32'(cyc - t0), 32'd4);
    i_zx_r[2] = 1'b1;
    idle(3);

    // Join rule: data without select never transfers
    i_a_v = 1'b1; i_a_d = 8'h5A; i_s_d = 2'd1; i_s_v = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("join_block", 32'(o_a_r), 32'd0);
    end
    @(posedge clk); #1 i_s_v = 1'b1;
    @(negedge clk);
    check("join_go", 32'(o_a_r), 32'd1);
    @(posedge clk); #1 i_a_v = 1'b0; i_s_v = 1'b0;
    idle(2);

    // Out-of-range select is consumed and flagged
    send(2'd3, 8'hAB);
    @(negedge clk);
    check("err_pulse", 32'(o_err), 32'd1);
    check("err_no_v", 32'(o_zx_v), 32'd0);
    @(negedge clk);
    check("err_clear", 32'(o_err), 32'd0);
    idle(1);

    // Reset mid-stream flushes full slots
    i_zx_r = 3'b100;
    send(2'd0, 8'hD0);
    send(2'd0, 8'hD1);
    send(2'd1, 8'hE0);
    send(2'd1, 8'hE1);
    i_a_v = 1'b1; i_s_v = 1'b1; i_s_d = 2'd0; i_a_d = 8'hF0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ar", 32'(o_a_r), 32'd0);
    check("rst_mid_sr", 32'(o_s_r), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_flush", 32'(o_zx_v), 32'd0);
    check("rst_resume", 32'(o_a_r), 32'd1);
    @(posedge clk); #1 i_a_v = 1'b0; i_s_v = 1'b0;
    @(negedge clk);
    check("rst_new_tok", 32'(o_zx_d[7:0]), 32'hF0);

    i_zx_r = '1;
    idle(4);
    for (int k = 0; k < R; k++)
      check($sformatf("drain[%0d]", k), 32'(q[k].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
